// File: rtl/reg_port_seq_pkg.sv
// Shared width defaults and FSM state encoding for the register-file port sequencer.
// The bypass option (REG_PORT_SEQ_BYPASS_EN) does not change anything defined here.
package reg_port_seq_pkg;

  localparam int unsigned REG_SZ_DEFAULT = 32;
  localparam int unsigned IDX_W_DEFAULT  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRd1Iss,
    StRd1Cap,
    StRd2Iss,
    StRd2Cap,
    StResp,
    StWbIss,
    StWbDone
  } state_e;

endpackage

// File: rtl/reg_port_seq_bypass.sv
// Single last-write entry used to short-circuit source reads.
// Index 0 always hits and returns zero; it is only instantiated under REG_PORT_SEQ_BYPASS_EN.
module reg_port_seq_bypass
  import reg_port_seq_pkg::*;
#(
  parameter int unsigned REG_SZ = REG_SZ_DEFAULT,
  parameter int unsigned IDX_W  = IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [REG_SZ-1:0] upd_data,
  input  logic [IDX_W-1:0]  idx_a,
  input  logic [IDX_W-1:0]  idx_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [REG_SZ-1:0] data_a,
  output logic [REG_SZ-1:0] data_b
);

  logic              ent_valid;
  logic [IDX_W-1:0]  ent_idx;
  logic [REG_SZ-1:0] ent_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= 1'b0;
      ent_idx   <= '0;
      ent_data  <= '0;
    end else if (upd) begin
      ent_valid <= 1'b1;
      ent_idx   <= upd_idx;
      ent_data  <= upd_data;
    end
  end

  always_comb begin
    hit_a  = (idx_a == '0) || (ent_valid && (ent_idx == idx_a));
    hit_b  = (idx_b == '0) || (ent_valid && (ent_idx == idx_b));
    data_a = (idx_a == '0) ? '0 : ent_data;
    data_b = (idx_b == '0) ? '0 : ent_data;
  end

endmodule

// File: rtl/reg_port_seq.sv
// Sequences two-source reads and single writebacks onto a one-port register file.
// Define REG_PORT_SEQ_BYPASS_EN to add a last-write bypass that skips file reads on a hit.
module reg_port_seq
  import reg_port_seq_pkg::*;
#(
  parameter int unsigned REG_SZ = REG_SZ_DEFAULT,
  parameter int unsigned IDX_W  = IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [IDX_W-1:0]  rs1,
  input  logic [IDX_W-1:0]  rs2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [REG_SZ-1:0] rs1_val,
  output logic [REG_SZ-1:0] rs2_val,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [REG_SZ-1:0] wb_data,
  output logic [IDX_W-1:0]  r_idx,
  output logic              re,
  output logic [IDX_W-1:0]  w_idx,
  output logic              we,
  output logic [REG_SZ-1:0] din,
  input  logic [REG_SZ-1:0] dout
);

  state_e           state;
  logic [IDX_W-1:0] rs2_idx;
  logic             idle;

  assign idle = (state == StIdle);

  // Writes take priority so a read issued alongside a write sees the new value.
  assign wb_ready = idle && !rst;
  assign rd_ready = idle && !rst && !wb_valid;

`ifdef REG_PORT_SEQ_BYPASS_EN
  logic              hit1;
  logic              hit2;
  logic [REG_SZ-1:0] byp1;
  logic [REG_SZ-1:0] byp2;
  logic              rs2_hit;
  logic              ent_upd;

  assign ent_upd = (state == StWbIss) && (w_idx != '0);

  reg_port_seq_bypass #(
    .REG_SZ (REG_SZ),
    .IDX_W  (IDX_W)
  ) u_bypass (
    .clk      (clk),
    .rst      (rst),
    .upd      (ent_upd),
    .upd_idx  (w_idx),
    .upd_data (din),
    .idx_a    (rs1),
    .idx_b    (rs2),
    .hit_a    (hit1),
    .hit_b    (hit2),
    .data_a   (byp1),
    .data_b   (byp2)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      re         <= 1'b0;
      we         <= 1'b0;
      resp_valid <= 1'b0;
      rs1_val    <= '0;
      rs2_val    <= '0;
      r_idx      <= '0;
      w_idx      <= '0;
      din        <= '0;
      rs2_idx    <= '0;
`ifdef REG_PORT_SEQ_BYPASS_EN
      rs2_hit    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle pulses; only the issuing transitions raise them.
      re <= 1'b0;
      we <= 1'b0;
      unique case (state)
        StIdle: begin
          if (wb_valid) begin
            state <= StWbIss;
            w_idx <= wb_idx;
            din   <= wb_data;
            we    <= (wb_idx != '0);
          end else if (rd_valid) begin
            rs2_idx <= rs2;
`ifdef REG_PORT_SEQ_BYPASS_EN
            rs2_hit <= hit2;
            if (hit2) rs2_val <= byp2;
            if (hit1) begin
              rs1_val <= byp1;
              if (hit2) begin
                state      <= StResp;
                resp_valid <= 1'b1;
              end else begin
                state <= StRd2Iss;
                re    <= 1'b1;
                r_idx <= rs2;
              end
            end else begin
              state <= StRd1Iss;
              re    <= 1'b1;
              r_idx <= rs1;
            end
`else
            state <= StRd1Iss;
            re    <= 1'b1;
            r_idx <= rs1;
`endif
          end
        end
        StRd1Iss: state <= StRd1Cap;
        StRd1Cap: begin
          rs1_val <= dout;
`ifdef REG_PORT_SEQ_BYPASS_EN
          if (rs2_hit) begin
            state      <= StResp;
            resp_valid <= 1'b1;
          end else begin
            state <= StRd2Iss;
            re    <= 1'b1;
            r_idx <= rs2_idx;
          end
`else
          state <= StRd2Iss;
          re    <= 1'b1;
          r_idx <= rs2_idx;
`endif
        end
        StRd2Iss: state <= StRd2Cap;
        StRd2Cap: begin
          rs2_val    <= dout;
          state      <= StResp;
          resp_valid <= 1'b1;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= StIdle;
          end
        end
        StWbIss:  state <= StWbDone;
        StWbDone: state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_seq.sv
// Self-checking bench for reg_port_seq: directed tables, corner sequences and a random mix
// scored against a register-file reference model; also covers the REG_PORT_SEQ_BYPASS_EN build.
module tb_reg_port_seq;

  localparam int unsigned REG_SZ = 32;
  localparam int unsigned IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_valid, rd_ready, resp_valid, resp_ready;
  logic [IDX_W-1:0]  rs1, rs2, wb_idx, r_idx, w_idx;
  logic [REG_SZ-1:0] rs1_val, rs2_val, wb_data, din, dout;
  logic              wb_valid, wb_ready, re, we;
  logic              load;

  always #5 clk = ~clk;

  reg_port_seq #(
    .REG_SZ (REG_SZ),
    .IDX_W  (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .r_idx      (r_idx),
    .re         (re),
    .w_idx      (w_idx),
    .we         (we),
    .din        (din),
    .dout       (dout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [REG_SZ-1:0] init_val(input int i);
    if (i == 0) return '0;
    if (i == 3) return 32'h11;
    if (i == 7) return 32'h22;
    return 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // Register file attached to the port: read data appears the cycle after re.
  logic [REG_SZ-1:0] fmem [32];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) fmem[i] <= init_val(i);
    end else begin
      if (re) dout <= fmem[r_idx];
      if (we) fmem[w_idx] <= din;
    end
  end

  // Reference model: architectural register contents plus last-write entry.
  logic [REG_SZ-1:0] ref_mem [32];
  bit                last_vld;
  logic [IDX_W-1:0]  last_idx;

  function automatic bit is_byp(input logic [IDX_W-1:0] i);
`ifdef REG_PORT_SEQ_BYPASS_EN
    return (i == 0) || (last_vld && last_idx == i);
`else
    return (i != i);
`endif
  endfunction

  task automatic ref_write(input logic [IDX_W-1:0] idx, input logic [REG_SZ-1:0] data);
    if (idx != 0) begin
      ref_mem[idx] = data;
      last_vld     = 1'b1;
      last_idx     = idx;
    end
  endtask

  // re/we exclusivity and spacing monitor
  bit prev_re = 1'b0, prev_we = 1'b0;
  int proto_err = 0;
  always @(negedge clk) begin
    if ((re && we) || ((re || we) && (prev_re || prev_we))) proto_err++;
    prev_re = re;
    prev_we = we;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [REG_SZ-1:0] data);
    int n = 0;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_idx   = idx;
    wb_data  = data;
    #1;
    while (!wb_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wr_accept", wb_ready, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    wb_idx   = IDX_W'($urandom);
    wb_data  = $urandom;
    ref_write(idx, data);
    check("wr_we_t1", we, (idx != 0));
    check("wr_widx_t1", w_idx, idx);
    check("wr_din_t1", din, data);
    check("wr_ready_t1", wb_ready, 0);
    @(negedge clk);
    check("wr_we_t2", we, 0);
    check("wr_widx_t2", w_idx, idx);
    check("wr_din_t2", din, data);
    @(negedge clk);
    check("wr_ready_t3", wb_ready, 1);
    check("wr_we_t3", we, 0);
  endtask

  task automatic rd_accept();
    int n = 0;
    #1;
    while (!rd_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rd_accept", rd_ready, 1);
    @(negedge clk);
    rd_valid = 1'b0;
    rs1      = IDX_W'($urandom);
    rs2      = IDX_W'($urandom);
  endtask

  task automatic rd_collect(input int bp, output logic [REG_SZ-1:0] v1,
                            output logic [REG_SZ-1:0] v2, output int lat, output int rcnt,
                            output logic [7:0] rmask);
    bit done = 1'b0;
    lat   = 1;
    rcnt  = 0;
    rmask = '0;
    while (!done) begin
      if (re) begin
        rcnt++;
        if (lat < 8) rmask[lat] = 1'b1;
      end
      if (resp_valid || lat >= 40) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    v1 = rs1_val;
    v2 = rs2_val;
    check("rd_resp_seen", resp_valid, 1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", resp_valid, 1);
      check("bp_rs1_stable", rs1_val, v1);
      check("bp_rs2_stable", rs2_val, v2);
      check("bp_rd_ready", rd_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("resp_idle_ready", rd_ready, 1);
  endtask

  task automatic read_chk(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b, input int bp,
                          input string tag, output logic [REG_SZ-1:0] v1,
                          output logic [REG_SZ-1:0] v2, output logic [7:0] rmask);
    logic [REG_SZ-1:0] e1, e2;
    int nb, lat, rcnt;
    e1 = ref_mem[a];
    e2 = ref_mem[b];
    nb = (is_byp(a) ? 0 : 1) + (is_byp(b) ? 0 : 1);
    @(negedge clk);
    rd_valid = 1'b1;
    rs1      = a;
    rs2      = b;
    rd_accept();
    rd_collect(bp, v1, v2, lat, rcnt, rmask);
    check({tag, "_rs1_val"}, v1, e1);
    check({tag, "_rs2_val"}, v2, e2);
    check({tag, "_latency"}, lat, 1 + 2 * nb);
    check({tag, "_re_count"}, rcnt, nb);
  endtask

  typedef struct {
    bit                wr;
    logic [IDX_W-1:0]  a;
    logic [IDX_W-1:0]  b;
    logic [REG_SZ-1:0] data;
    logic [REG_SZ-1:0] e1;
    logic [REG_SZ-1:0] e2;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [REG_SZ-1:0] v1, v2, wd;
    logic [7:0]        rmask;
    logic [IDX_W-1:0]  ra, rb;
    bit                rose;

    tbl[0] = '{1'b1, 5'd5, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 5'd0, 5'd0, 32'h0000_1234, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 5'd5, 5'd0, 32'h0, 32'h0000_DEAD, 32'h0};
    tbl[3] = '{1'b0, 5'd3, 5'd7, 32'h0, 32'h11, 32'h22};
    tbl[4] = '{1'b1, 5'd7, 5'd0, 32'h99, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 5'd7, 5'd7, 32'h0, 32'h99, 32'h99};
    tbl[6] = '{1'b0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h11};
    tbl[7] = '{1'b1, 5'd3, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 5'd3, 5'd5, 32'h0, 32'hCAFE_F00D, 32'h0000_DEAD};

    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    last_vld   = 1'b0;
    last_idx   = '0;
    rst        = 1'b1;
    load       = 1'b1;
    rd_valid   = 1'b1;
    wb_valid   = 1'b0;
    resp_ready = 1'b0;
    rs1        = '0;
    rs2        = '0;
    wb_idx     = '0;
    wb_data    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_ready", rd_ready, 0);
    wb_valid = 1'b1;
    #1;
    check("rst_wb_ready", wb_ready, 0);
    check("rst_re", re, 0);
    check("rst_we", we, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rs1_val", rs1_val, 0);
    check("rst_rs2_val", rs2_val, 0);
    check("rst_r_idx", r_idx, 0);
    check("rst_w_idx", w_idx, 0);
    check("rst_din", din, 0);
    @(negedge clk);
    rd_valid = 1'b0;
    wb_valid = 1'b0;
    load     = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic read timing: re at T+1 and T+3, response at T+5
    read_chk(5'd3, 5'd7, 0, "basic_rd", v1, v2, rmask);
    check("basic_rd_re_slots", rmask, 8'b0000_1010);

    // Basic write timing
    do_write(5'd5, 32'h0000_DEAD);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].a, tbl[i].data);
      end else begin
        read_chk(tbl[i].a, tbl[i].b, 0, "tbl", v1, v2, rmask);
        check($sformatf("tbl%0d_rs1", i), v1, tbl[i].e1);
        check($sformatf("tbl%0d_rs2", i), v2, tbl[i].e2);
      end
    end

    // Simultaneous read and write: write wins, read then sees the new data
    @(negedge clk);
    wd       = 32'h4444_0004;
    wb_valid = 1'b1;
    wb_idx   = 5'd4;
    wb_data  = wd;
    rd_valid = 1'b1;
    rs1      = 5'd4;
    rs2      = 5'd4;
    #1;
    check("sim_wb_ready", wb_ready, 1);
    check("sim_rd_ready", rd_ready, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    ref_write(5'd4, wd);
    check("sim_we_first", we, 1);
    check("sim_rd_blocked", rd_ready, 0);
    begin
      int lat, rcnt, nb;
      nb = is_byp(5'd4) ? 0 : 2;
      rd_accept();
      rd_collect(0, v1, v2, lat, rcnt, rmask);
      check("sim_rs1_new", v1, wd);
      check("sim_rs2_new", v2, wd);
      check("sim_latency", lat, 1 + 2 * nb);
      check("sim_re_count", rcnt, nb);
    end

    // Backpressure held for 4 cycles
    read_chk(5'd5, 5'd3, 4, "bp_rd", v1, v2, rmask);

    // Reset in RD2_ISS
    @(negedge clk);
    rd_valid = 1'b1;
    rs1      = 5'd10;
    rs2      = 5'd11;
    rd_accept();
    check("rstmid_re_t1", re, 1);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_re_t3", re, 1);
    rst = 1'b1;
    #1;
    last_vld = 1'b0;
    check("rstmid_re_low", re, 0);
    check("rstmid_rd_ready", rd_ready, 0);
    check("rstmid_wb_ready", wb_ready, 0);
    check("rstmid_r_idx", r_idx, 0);
    rose = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) rose = 1'b1;
    end
    rst = 1'b0;
    #1;
    check("rstmid_idle_ready", rd_ready, 1);
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) rose = 1'b1;
    end
    check("rstmid_no_resp", rose, 0);

`ifdef REG_PORT_SEQ_BYPASS_EN
    // Both sources bypassed: no file read, response one cycle after acceptance
    do_write(5'd9, 32'h55);
    read_chk(5'd9, 5'd0, 0, "byp_rd", v1, v2, rmask);
    check("byp_rs1", v1, 32'h55);
    check("byp_rs2", v2, 32'h0);
    check("byp_no_re", rmask, 8'h00);
`endif

    // Random mix against the reference model
    for (int k = 0; k < 200; k++) begin
      ra = IDX_W'($urandom_range(0, 7));
      rb = IDX_W'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) do_write(ra, $urandom);
      else read_chk(ra, rb, $urandom_range(0, 2), "rnd", v1, v2, rmask);
    end

    check("protocol_strobe_spacing", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_port_seq.md
REG_PORT_SEQ -- requirements
Module: reg_port_seq

Interface
REQ-001 The block SHALL have parameter REG_SZ, default 32, meaning register data width.
REQ-002 The block SHALL have parameter IDX_W, default 5, meaning register index width.
REQ-003 The block SHALL have these ports. Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  async reset, active-high
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted
- rs1  in  IDX_W  first source index
- rs2  in  IDX_W  second source index
- resp_valid  out  1  read response valid
- resp_ready  in  1  response consumed
- rs1_val  out  REG_SZ  first source value
- rs2_val  out  REG_SZ  second source value
- wb_valid  in  1  writeback valid
- wb_ready  out  1  writeback accepted
- wb_idx  in  IDX_W  writeback index
- wb_data  in  REG_SZ  writeback data
- r_idx  out  IDX_W  register-file read index
- re  out  1  register-file read strobe; the file samples on its rising edge
- w_idx  out  IDX_W  register-file write index
- we  out  1  register-file write strobe; the file writes on its rising edge
- din  out  REG_SZ  register-file write data
- dout  in  REG_SZ  register-file read data

Function
REQ-004 The FSM SHALL have the states IDLE, RD1_ISS, RD1_CAP, RD2_ISS, RD2_CAP, RESP, WB_ISS and WB_DONE.
REQ-005 rd_ready and wb_ready SHALL be high only in IDLE. When both rd_valid and wb_valid are high, wb_ready SHALL win and rd_ready SHALL be low.
REQ-006 Read accepted in cycle T:
- RD1_ISS in T+1: re=1, r_idx=rs1.
- RD1_CAP in T+2: re=0, r_idx held; rs1_val<=dout.
- RD2_ISS and RD2_CAP do the same for rs2.
- RESP in T+5.
REQ-007 rs1 and rs2 SHALL be registered on acceptance. Later input changes SHALL have no effect.
REQ-008 In RESP, resp_valid=1 and rs1_val/rs2_val SHALL be held stable until resp_ready=1. The block then returns to IDLE on the next cycle.
REQ-009 Write accepted in cycle T:
- WB_ISS in T+1: we=1, w_idx=wb_idx, din=wb_data.
- WB_DONE in T+2: we=0, w_idx and din held.
- IDLE in T+3.
REQ-010 A write with wb_idx=0 SHALL be accepted, SHALL never assert we, and SHALL still pass through WB_ISS and WB_DONE.
REQ-011 re and we SHALL each be high for exactly one cycle per access. They SHALL never be high in the same cycle, and never high in consecutive cycles.
REQ-012 A write accepted while a response is pending is impossible, because wb_ready=0 outside IDLE. This ordering SHALL guarantee read-after-write visibility.
REQ-013 When rs1 equals rs2, the block SHALL still perform two strobes.

Reset
REQ-014 While rst=1, the state SHALL be IDLE and all of the following SHALL be 0: re, we, resp_valid, rs1_val, rs2_val, r_idx, w_idx, din.
REQ-015 rst asserted mid-access SHALL abort the access, drop any pending response, and force re/we low immediately. rd_ready and wb_ready SHALL be 0 while rst=1.

Configuration
REQ-016 With macro REG_PORT_SEQ_BYPASS_EN defined, the block SHALL keep a single last-write entry (valid, idx, data). The entry SHALL be updated in WB_ISS when idx≠0 and cleared on rst.
- A source whose index matches a valid entry SHALL take the entry's data and skip its ISS/CAP states, with no re.
- A source with index 0 SHALL yield 0 and skip its ISS/CAP states.
- If both sources are bypassed, RESP SHALL come at T+1.
REQ-017 Without REG_PORT_SEQ_BYPASS_EN, the behaviour SHALL be exactly REQ-006 for every index, and no bypass storage SHALL exist.

Structure
REQ-018 Package reg_port_seq_pkg SHALL hold the REG_SZ/IDX_W defaults and the FSM state typedef.
REQ-019 The bypass entry SHALL be the sub-module reg_port_seq_bypass, instantiated only under REG_PORT_SEQ_BYPASS_EN. Everything else SHALL be flat, in roughly 200–300 lines.

Verification
REQ-020 Read: rs1=3, rs2=7 against a model holding x3=0x11, x7=0x22, without bypass. The bench SHALL check re pulses at T+1 and T+3, resp_valid at T+5, rs1_val=0x11, rs2_val=0x22.
REQ-021 Write: wb_idx=5, wb_data=0xDEAD. The bench SHALL check we high only at T+1, w_idx=5, din=0xDEAD held through T+2, wb_ready=1 again at T+3.
REQ-022 Simultaneous: rd_valid=wb_valid=1 in IDLE. The bench SHALL check the write completes first, then the read of the same index returns the new data.
REQ-023 Backpressure: resp_ready=0 for 4 cycles. The bench SHALL check resp_valid and the values stay stable, and rd_ready=0, until the handshake.
REQ-024 Reset during RD2_ISS. The bench SHALL check re=0 immediately, resp_valid never rises, and the block is in IDLE with rd_ready=1 after reset releases.
REQ-025 Bypass-enabled: write x9=0x55, then read rs1=9, rs2=0. The bench SHALL check there is no re pulse, resp_valid at T+1, rs1_val=0x55, rs2_val=0.
